// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: MIPS function codes,
// controller states and the decoded operation enum.
package mdu_pkg;

  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MTHI  = 6'b010001;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MTLO  = 6'b010011;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } state_t;

  typedef enum logic [2:0] {
    OP_MUL,
    OP_MULU,
    OP_DIV,
    OP_DIVU,
    OP_MTHI,
    OP_MTLO,
    OP_MF,
    OP_BAD
  } op_t;

  function automatic logic op_is_iter(input op_t op);
    return (op == OP_MUL) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_decode.sv
// Combinational decode of the R-type func field into an MDU operation.
module mdu_decode
  import mdu_pkg::*;
(
  input  logic [5:0] i_func,
  output op_t        o_op
);

  always_comb begin
    o_op = OP_BAD;
    unique case (i_func)
      FN_MULT:  o_op = OP_MUL;
      FN_MULTU: o_op = OP_MULU;
      FN_DIV:   o_op = OP_DIV;
      FN_DIVU:  o_op = OP_DIVU;
      FN_MTHI:  o_op = OP_MTHI;
      FN_MTLO:  o_op = OP_MTLO;
      FN_MFHI:  o_op = OP_MF;
      FN_MFLO:  o_op = OP_MF;
      default:  o_op = OP_BAD;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Iterative multiply/divide unit with HI/LO registers. One bit per cycle in
// RUN (shift-add multiply, restoring divide), sign correction in FIX.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  state_t             r_state, w_state_next;
  op_t                w_op;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_acc, w_acc_step, w_prod;
  logic [WIDTH-1:0]   r_opa, r_opb, r_hi, r_lo;
  logic               r_is_div, r_neg_a, r_neg_b, r_done, r_illegal;

  logic               w_signed, w_is_div, w_neg_a, w_neg_b;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH+1:0]   w_div_diff;
  logic [WIDTH-1:0]   w_quo, w_rem, w_a_orig, w_fix_hi, w_fix_lo;

  mdu_decode u_decode (
    .i_func (func),
    .o_op   (w_op)
  );

  assign w_signed = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_is_div = (w_op == OP_DIV) || (w_op == OP_DIVU);
  assign w_neg_a  = w_signed & a[WIDTH-1];
  assign w_neg_b  = w_signed & b[WIDTH-1];
  assign w_mag_a  = w_neg_a ? -a : a;
  assign w_mag_b  = w_neg_b ? -b : b;

  // Multiply: r_opa is the multiplicand, multiplier bits leave from acc[0].
  // Divide: r_opb is the divisor, remainder builds in the upper half.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : '0);
    w_div_diff = {1'b0, r_acc[2*WIDTH-1:WIDTH-1]} - {2'b00, r_opb};
    w_acc_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    if (r_is_div) begin
      if (!w_div_diff[WIDTH+1])
        w_acc_step = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
      else
        w_acc_step = {r_acc[2*WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    w_prod   = (r_neg_a ^ r_neg_b) ? -r_acc : r_acc;
    w_quo    = (r_neg_a ^ r_neg_b) ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    w_rem    = r_neg_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_a_orig = r_neg_a ? -r_opa : r_opa;
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (r_is_div) begin
      if (r_opb == '0) begin
        w_fix_hi = w_a_orig;
        w_fix_lo = '1;
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quo;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (start && op_is_iter(w_op)) w_state_next = ST_RUN;
      ST_RUN:  if (r_cnt == LAST_ITER) w_state_next = ST_FIX;
      ST_FIX:  w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_a   <= 1'b0;
      r_neg_b   <= 1'b0;
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            case (w_op)
              OP_MUL, OP_MULU, OP_DIV, OP_DIVU: begin
                r_opa    <= w_mag_a;
                r_opb    <= w_mag_b;
                r_neg_a  <= w_neg_a;
                r_neg_b  <= w_neg_b;
                r_is_div <= w_is_div;
                r_cnt    <= '0;
                r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
              end
              OP_MTHI: begin
                r_hi   <= a;
                r_done <= 1'b1;
              end
              OP_MTLO: begin
                r_lo   <= a;
                r_done <= 1'b1;
              end
              OP_MF:   ;
              default: r_illegal <= 1'b1;
            endcase
          end
        end
        ST_RUN: begin
          r_acc <= w_acc_step;
          r_cnt <= r_cnt + CW'(1);
        end
        ST_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
          r_cnt  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state != ST_IDLE);
  assign done    = r_done;
  assign illegal = r_illegal;
  assign hi      = r_hi;
  assign lo      = r_lo;
  assign rd_data = (func == FN_MFHI) ? r_hi :
                   (func == FN_MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed and random ops checked against an
// arithmetic HI/LO model; a negedge monitor compares every done/illegal pulse.
module tb_mdu_ctrl;

  localparam int W = 32;
  localparam logic [5:0] C_MFHI = 6'b010000, C_MTHI = 6'b010001;
  localparam logic [5:0] C_MFLO = 6'b010010, C_MTLO = 6'b010011;
  localparam logic [5:0] C_MULT = 6'b011000, C_MULTU = 6'b011001;
  localparam logic [5:0] C_DIV  = 6'b011010, C_DIVU  = 6'b011011;
  localparam logic [5:0] C_BAD  = 6'b100000;

  typedef struct {
    bit         dn;
    bit         ill;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [5:0]   func = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, illegal;
  logic [W-1:0] hi, lo, rd_data;

  int total = 0;
  int bad = 0;
  exp_t q[$];
  logic [W-1:0] m_hi = '0, m_lo = '0;

  mdu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .a(a), .b(b),
    .busy(busy), .done(done), .illegal(illegal), .hi(hi), .lo(lo), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic bit is_iter(input logic [5:0] f);
    return f == C_MULT || f == C_MULTU || f == C_DIV || f == C_DIVU;
  endfunction

  // Architectural effect of one request on HI/LO, from plain arithmetic.
  function automatic exp_t model(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv);
    exp_t e;
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    e.dn = 1'b1; e.ill = 1'b0; e.hi = m_hi; e.lo = m_lo;
    case (f)
      C_MULTU: begin p = {32'b0, av} * {32'b0, bv}; e.hi = p[63:32]; e.lo = p[31:0]; end
      C_MULT:  begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
      C_DIVU: begin
        if (bv == 0) begin e.hi = av; e.lo = '1; end
        else begin e.hi = av % bv; e.lo = av / bv; end
      end
      C_DIV: begin
        if (bv == 0) begin e.hi = av; e.lo = '1; end
        else if (av == 32'h80000000 && bv == 32'hFFFFFFFF) begin e.hi = '0; e.lo = 32'h80000000; end
        else begin e.hi = 32'(sa % sb); e.lo = 32'(sa / sb); end
      end
      C_MTHI: e.hi = av;
      C_MTLO: e.lo = av;
      C_MFHI, C_MFLO: e.dn = 1'b0;
      default: begin e.dn = 1'b0; e.ill = 1'b1; end
    endcase
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && (done || illegal)) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_pulse: got done=%0b illegal=%0b expected none", done, illegal);
      end else begin
        exp_t e;
        e = q.pop_front();
        $display("txn done=%0b illegal=%0b hi=%h lo=%h", done, illegal, hi, lo);
        check("pulse_kind", {62'b0, done, illegal}, {62'b0, e.dn, e.ill});
        if (e.dn) begin
          check("hi", 64'(hi), 64'(e.hi));
          check("lo", 64'(lo), 64'(e.lo));
        end
      end
    end
  end

  // Called at a negedge; returns at a negedge (the done cycle for iterative ops).
  task automatic issue(input logic [5:0] f, input logic [W-1:0] av, input logic [W-1:0] bv,
                       input bit poke_busy);
    exp_t e;
    logic [W-1:0] old_hi, old_lo;
    int cnt;
    old_hi = m_hi; old_lo = m_lo;
    e = model(f, av, bv);
    if (e.dn || e.ill) q.push_back(e);
    m_hi = e.hi; m_lo = e.lo;
    start = 1'b1; func = f; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    if (is_iter(f)) begin
      cnt = 0;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!busy) break;
        cnt++;
        if (poke_busy && cnt == 5) begin
          start = 1'b1; func = C_MULT; a = $urandom; b = $urandom;
        end
        if (poke_busy && cnt == 8) func = C_BAD;
        if (poke_busy && cnt == 11) begin start = 1'b0; func = f; end
        if (hi !== old_hi || lo !== old_lo) check("hold_hilo", {hi, lo}, {old_hi, old_lo});
      end
      check("busy_cycles", 64'(cnt), 64'(W + 1));
      check("done_after_busy", {63'b0, done}, 64'd1);
    end else begin
      @(negedge clk);
      check("no_busy", {63'b0, busy}, 64'd0);
      if (f == C_MFHI) check("rd_mfhi", 64'(rd_data), 64'(m_hi));
      if (f == C_MFLO) check("rd_mflo", 64'(rd_data), 64'(m_lo));
    end
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h80000000;
      2: return '1;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [5:0] codes [10];
    codes = '{C_MULT, C_MULTU, C_DIV, C_DIVU, C_MTHI, C_MTLO, C_MFHI, C_MFLO, C_BAD, 6'b000000};

    repeat (2) @(negedge clk);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_flags", {62'b0, done, illegal}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(C_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    issue(C_MULT,  32'hFFFFFFFD, 32'd7, 1'b0);
    issue(C_DIV,   32'hFFFFFFF9, 32'd2, 1'b0);
    issue(C_DIVU,  32'd7, 32'd2, 1'b0);
    issue(C_DIV,   32'h80000000, 32'hFFFFFFFF, 1'b0);
    issue(C_DIVU,  32'h12345678, 32'd0, 1'b0);
    issue(C_DIV,   32'hFFFFFF00, 32'd0, 1'b0);
    issue(C_MTHI,  32'hA5A5A5A5, 32'd0, 1'b0);
    issue(C_MFHI,  32'd0, 32'd0, 1'b0);
    issue(C_MTLO,  32'h5A5A0F0F, 32'd0, 1'b0);
    issue(C_MFLO,  32'd0, 32'd0, 1'b0);
    issue(C_MULT,  32'h12345678, 32'h9ABCDEF0, 1'b1);
    issue(C_BAD,   32'd1, 32'd2, 1'b0);

    for (int n = 0; n < 40; n++)
      issue(codes[$urandom_range(0, 9)], pick_operand(), pick_operand(), ($urandom_range(0, 3) == 0));

    // Abort a multiply ten cycles in; no done may follow.
    start = 1'b1; func = C_MULT; a = $urandom | 32'h1; b = $urandom | 32'h100;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_before_rst", {63'b0, busy}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("idle_after_abort", {63'b0, busy}, 64'd0);
    check("hilo_after_abort", {hi, lo}, {m_hi, m_lo});
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Iterative multiply/divide unit with HI/LO registers for the multicycle CPU, parametrised in datapath width. Sits beside the ALU and is driven by the R-type `func` field, using the same MIPS function encoding as the ALU control path. It executes MULT/MULTU/DIV/DIVU over multiple cycles with a start/busy/done handshake. It services MTHI/MTLO/MFHI/MFLO so the control FSM can stall on `busy`.

## Interface
- `WIDTH`, default 32: operand and HI/LO width; must be at least 4.
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: asynchronous reset, active-low.
- `start`, in, 1: request; sampled on a rising edge together with `func`, `a` and `b`.
- `func`, in, 6: MIPS function code.
- `a`, in, `WIDTH`: rs operand; dividend or multiplicand.
- `b`, in, `WIDTH`: rt operand; divisor or multiplier.
- `busy`, out, 1: iterative operation in progress.
- `done`, out, 1: one-cycle pulse; HI/LO hold final values while it is high.
- `illegal`, out, 1: one-cycle pulse; `start` was sampled with an unsupported `func`.
- `hi`, out, `WIDTH`: HI register.
- `lo`, out, `WIDTH`: LO register.
- `rd_data`, out, `WIDTH`: combinational; `hi` when `func`=MFHI, `lo` when `func`=MFLO, otherwise 0.

## Operation
- Function codes:
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
- FSM states: IDLE, RUN, FIX.
- IDLE:
  - `start` with MULT/MULTU/DIV/DIVU: capture operand magnitudes (signed ops only) and the sign flags, clear the counter, go to RUN.
  - `start` with MTHI: `hi`<=`a`. With MTLO: `lo`<=`a`. Either one pulses `done` next cycle and does not assert `busy`.
  - `start` with MFHI/MFLO: no state change and no `done`, because the read is combinational.
  - `start` with any other code: pulse `illegal`; no state change.
- RUN: exactly `WIDTH` iterations, one bit per cycle.
  - Multiply: shift-add on a 2·`WIDTH` accumulator.
  - Divide: restoring division; remainder in the upper half, quotient in the lower half.
- FIX, one cycle:
  - Signed multiply: negate the 2·`WIDTH` product if the operand signs differ.
  - Signed divide: quotient sign is sign(a) XOR sign(b); remainder takes sign(a).
  - On exit, write `hi` (product[2W-1:W] or remainder) and `lo` (product[W-1:0] or quotient), pulse `done`, return to IDLE.
- Divide by zero, signed or unsigned: `lo`=all ones, `hi`=`a`. Latency is unchanged.
- DIV of the most negative value by -1: `lo`=most negative value, `hi`=0. No trap.
- `start` while `busy`: ignored completely, with no `illegal` pulse. The control FSM must hold the request.
- Reset, including mid-operation:
  - `hi`, `lo`, `busy`, `done`, `illegal` all go to 0.
  - State goes to IDLE and the counter to 0.
  - No `done` is produced for the aborted operation.

## Timing
- Call the edge that samples a MULT/DIV-class `start` E0.
- `busy` is high in the cycles after E0 through E`WIDTH`+1, i.e. `WIDTH`+1 cycles.
- `hi`/`lo` update on E`WIDTH`+1. `done` is high in the single cycle after E`WIDTH`+1, with `busy` low.
- A new `start` may be sampled on the edge that ends the `done` cycle (back-to-back, no bubble).
- MTHI/MTLO: register written on E0, `done` high in the cycle after E0.
- `illegal` is high in the cycle after the sampling edge.
- `hi`/`lo` hold their previous values throughout RUN and FIX.

## Structure
- Shared package `mdu_pkg`:
  - Function-code localparams, shared with ALU control.
  - State typedef (IDLE/RUN/FIX).
  - Op enum (MUL, MULU, DIV, DIVU, MTHI, MTLO, MF, BAD).
- One sub-module: `mdu_decode`, combinational `func` to op enum. `mdu_ctrl` instantiates it.
- Iteration counter width is $clog2(`WIDTH`+1).

## Test plan
All with `WIDTH`=32.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` in the cycle after E33; `busy` high for exactly 33 cycles.
- MULT a=0xFFFFFFFD (-3), b=7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB.
- DIV a=-7, b=2 -> `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=7, b=2 -> `lo`=3, `hi`=1. DIV a=0x80000000, b=-1 -> `lo`=0x80000000, `hi`=0.
- DIVU a=0x12345678, b=0 -> `hi`=0x12345678, `lo`=0xFFFFFFFF, same latency as other divides.
- MTHI a=0xA5A5A5A5, then `func`=MFHI -> `rd_data`=0xA5A5A5A5.
- `start` with MULT during RUN -> ignored and `hi`/`lo` unchanged until the first `done`. `start` with `func`=100000 -> `illegal` pulses once.
- Assert `rst_n`=0 ten cycles into a MULT -> `busy`, `hi`, `lo` go to 0 immediately and no `done` follows after release.
